up_axi_master: RTL
==================

# up_axi_master

AXI4-Lite initiator that converts the internal single-cycle up-bus request/acknowledge interface into AXI4-Lite master transactions. It is the counterpart of up_axi, which turns AXI4-Lite slave traffic into up-bus requests. Use it wherever a local controller, such as a TDD sequencer or a register-replay engine, must program an AXI4-Lite peripheral. The read and write paths are independent; each path has at most one outstanding transaction.

## Interface
Parameters:
- AXI_ADDRESS_WIDTH, 16, AXI byte-address width; up-bus word address is AXI_ADDRESS_WIDTH-2 bits.

Ports:
- up_clk  in  1  single clock for up bus and AXI master.
- up_rstn  in  1  asynchronous active-low reset.
- up_wreq  in  1  write request pulse; up_waddr/up_wdata sampled in the same cycle.
- up_waddr  in  AXI_ADDRESS_WIDTH-2  write word address.
- up_wdata  in  32  write data.
- up_wack  out  1  one-cycle pulse when the write completes.
- up_werr  out  1  one-cycle pulse with up_wack when bresp != 0.
- up_wbusy  out  1  write path not idle.
- up_rreq  in  1  read request pulse; up_raddr sampled in the same cycle.
- up_raddr  in  AXI_ADDRESS_WIDTH-2  read word address.
- up_rdata  out  32  read data, valid while up_rack=1 and held until the next rack.
- up_rack  out  1  one-cycle pulse when the read completes.
- up_rerr  out  1  one-cycle pulse with up_rack when rresp != 0.
- up_rbusy  out  1  read path not idle.
- m_axi_awvalid out 1 / m_axi_awaddr out AXI_ADDRESS_WIDTH / m_axi_awprot out 3 / m_axi_awready in 1.
- m_axi_wvalid out 1 / m_axi_wdata out 32 / m_axi_wstrb out 4 / m_axi_wready in 1.
- m_axi_bvalid in 1 / m_axi_bresp in 2 / m_axi_bready out 1.
- m_axi_arvalid out 1 / m_axi_araddr out AXI_ADDRESS_WIDTH / m_axi_arprot out 3 / m_axi_arready in 1.
- m_axi_rvalid in 1 / m_axi_rresp in 2 / m_axi_rdata in 32 / m_axi_rready out 1.

## Operation
- Address mapping: awaddr = {up_waddr, 2'b00} and araddr = {up_raddr, 2'b00}. awprot = arprot = 3'b000. wstrb = 4'hF.
- Write FSM has states W_IDLE, W_ADDR, W_RESP.
  - W_IDLE: on up_wreq, register the address and data, set awvalid = wvalid = 1, and go to W_ADDR.
  - W_ADDR: awvalid drops in the cycle after its awvalid&awready handshake; wvalid drops in the cycle after its wvalid&wready handshake. The two handshakes may occur in any order or in the same cycle. Once both have completed, set bready = 1 and go to W_RESP.
  - W_RESP: on bvalid&bready, set bready = 0, pulse up_wack next cycle with up_werr = |bresp, and return to W_IDLE.
- Read FSM has states R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: on up_rreq, set arvalid = 1 and go to R_ADDR.
  - R_ADDR: on arvalid&arready, set arvalid = 0, set rready = 1, and go to R_DATA.
  - R_DATA: on rvalid&rready, capture rdata into up_rdata, pulse up_rack with up_rerr = |rresp, clear rready, and return to R_IDLE.
- Valid outputs are never deasserted before their handshake. Address and data outputs are stable while the corresponding valid is high.
- A request that arrives while its path is busy is dropped: no AXI traffic and no ack. The requester must wait for the ack before issuing the next request.
- Simultaneous up_wreq and up_rreq: both paths start in the same cycle. There is no ordering between reads and writes.
- up_wbusy = (wstate != W_IDLE); up_rbusy = (rstate != R_IDLE).

## Timing
- Reset values:
  - All m_axi valid/ready outputs are 0.
  - m_axi_awaddr, m_axi_araddr, m_axi_wdata, up_rdata are 0.
  - up_wack, up_werr, up_rack, up_rerr are 0.
  - Both FSMs are idle.
- Reset mid-transaction returns both FSMs to idle immediately. The AXI slave must share the reset, and pending responses are discarded.
- Write latency, up_wreq at cycle 0:
  - awvalid/wvalid are high at cycle 1.
  - With awready = wready = 1 at cycle 1, bready is high at cycle 2.
  - With bvalid at cycle 2, up_wack is asserted at cycle 3. Minimum latency is 3 cycles.
- Read latency, up_rreq at cycle 0:
  - arvalid is high at cycle 1 and rready at cycle 2.
  - up_rack is asserted at cycle 3, minimum.
- Backpressure adds cycles 1:1. There is no timeout.
- A new request is accepted in the cycle after its ack. Back-to-back throughput is one transaction per 4 cycles per path.

## Test plan
- Write to up_waddr 0x0010, up_wdata 0xA5A5_0001 with the slave always ready and bresp = 0: awaddr = 0x0040, wstrb = 0xF, up_wack at cycle 3, up_werr = 0.
- Read from up_raddr 0x0003 with rdata = 0x1234_5678 and rresp = 0: araddr = 0x000C, up_rack at cycle 3, up_rdata = 0x1234_5678, held afterwards.
- Hold wready low for 5 cycles after awready: awvalid drops after 1 cycle, wvalid stays high with stable data for 5 cycles, and up_wack arrives at cycle 8.
- bresp = 2'b10 and rresp = 2'b11: up_werr and up_rerr pulse together with their acks.
- Simultaneous wreq and rreq, then a second wreq while up_wbusy = 1: both transactions complete, and the second wreq produces no AXI activity.
- Assert up_rstn low while in W_RESP and R_ADDR: all valid/ready outputs go to 0 asynchronously; after release no ack occurs and a new request completes normally.

Source files
------------

// File: rtl/up_axi_master.sv
// up_axi_master: up-bus request/ack to AXI4-Lite initiator bridge.
// Independent read and write paths, one outstanding transaction each.
module up_axi_master #(
    parameter int AXI_ADDRESS_WIDTH = 16
) (
    input  logic                         up_clk,
    input  logic                         up_rstn,
    input  logic                         up_wreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] up_waddr,
    input  logic [31:0]                  up_wdata,
    output logic                         up_wack,
    output logic                         up_werr,
    output logic                         up_wbusy,
    input  logic                         up_rreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] up_raddr,
    output logic [31:0]                  up_rdata,
    output logic                         up_rack,
    output logic                         up_rerr,
    output logic                         up_rbusy,
    output logic                         m_axi_awvalid,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]                   m_axi_awprot,
    input  logic                         m_axi_awready,
    output logic                         m_axi_wvalid,
    output logic [31:0]                  m_axi_wdata,
    output logic [3:0]                   m_axi_wstrb,
    input  logic                         m_axi_wready,
    input  logic                         m_axi_bvalid,
    input  logic [1:0]                   m_axi_bresp,
    output logic                         m_axi_bready,
    output logic                         m_axi_arvalid,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                   m_axi_arprot,
    input  logic                         m_axi_arready,
    input  logic                         m_axi_rvalid,
    input  logic [1:0]                   m_axi_rresp,
    input  logic [31:0]                  m_axi_rdata,
    output logic                         m_axi_rready
);

    localparam int UW = AXI_ADDRESS_WIDTH - 2;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t wstate, wstate_n;
    rstate_t rstate, rstate_n;

    logic [UW-1:0] waddr_q, waddr_n;
    logic [UW-1:0] raddr_q, raddr_n;
    logic [31:0]   wdata_q, wdata_n;
    logic [31:0]   rdata_n;
    logic awvalid_n, wvalid_n, bready_n, wack_n, werr_n;
    logic arvalid_n, rready_n, rack_n, rerr_n;

    assign m_axi_awaddr = {waddr_q, 2'b00};
    assign m_axi_araddr = {raddr_q, 2'b00};
    assign m_axi_wdata  = wdata_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;
    assign up_wbusy     = (wstate != W_IDLE);
    assign up_rbusy     = (rstate != R_IDLE);

    always_comb begin
        wstate_n  = wstate;
        waddr_n   = waddr_q;
        wdata_n   = wdata_q;
        awvalid_n = m_axi_awvalid;
        wvalid_n  = m_axi_wvalid;
        bready_n  = m_axi_bready;
        wack_n    = 1'b0;
        werr_n    = 1'b0;
        unique case (wstate)
            W_IDLE: begin
                if (up_wreq) begin
                    waddr_n   = up_waddr;
                    wdata_n   = up_wdata;
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    wstate_n  = W_ADDR;
                end
            end
            W_ADDR: begin
                // AW and W complete independently, in either order
                awvalid_n = m_axi_awvalid & ~m_axi_awready;
                wvalid_n  = m_axi_wvalid & ~m_axi_wready;
                if (!awvalid_n && !wvalid_n) begin
                    bready_n = 1'b1;
                    wstate_n = W_RESP;
                end
            end
            W_RESP: begin
                if (m_axi_bvalid) begin
                    bready_n = 1'b0;
                    wack_n   = 1'b1;
                    werr_n   = |m_axi_bresp;
                    wstate_n = W_IDLE;
                end
            end
            default: wstate_n = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_n  = rstate;
        raddr_n   = raddr_q;
        rdata_n   = up_rdata;
        arvalid_n = m_axi_arvalid;
        rready_n  = m_axi_rready;
        rack_n    = 1'b0;
        rerr_n    = 1'b0;
        unique case (rstate)
            R_IDLE: begin
                if (up_rreq) begin
                    raddr_n   = up_raddr;
                    arvalid_n = 1'b1;
                    rstate_n  = R_ADDR;
                end
            end
            R_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    rstate_n  = R_DATA;
                end
            end
            R_DATA: begin
                if (m_axi_rvalid) begin
                    rdata_n  = m_axi_rdata;
                    rack_n   = 1'b1;
                    rerr_n   = |m_axi_rresp;
                    rready_n = 1'b0;
                    rstate_n = R_IDLE;
                end
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            wstate        <= W_IDLE;
            waddr_q       <= '0;
            wdata_q       <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            up_wack       <= 1'b0;
            up_werr       <= 1'b0;
        end else begin
            wstate        <= wstate_n;
            waddr_q       <= waddr_n;
            wdata_q       <= wdata_n;
            m_axi_awvalid <= awvalid_n;
            m_axi_wvalid  <= wvalid_n;
            m_axi_bready  <= bready_n;
            up_wack       <= wack_n;
            up_werr       <= werr_n;
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            rstate        <= R_IDLE;
            raddr_q       <= '0;
            up_rdata      <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            up_rack       <= 1'b0;
            up_rerr       <= 1'b0;
        end else begin
            rstate        <= rstate_n;
            raddr_q       <= raddr_n;
            up_rdata      <= rdata_n;
            m_axi_arvalid <= arvalid_n;
            m_axi_rready  <= rready_n;
            up_rack       <= rack_n;
            up_rerr       <= rerr_n;
        end
    end

endmodule
